// File: rtl/bp_axis_pkt_fifo.sv
// AXI-Stream flit FIFO with FWFT output and a stored-packet counter.
// Define PKT_FIFO_STORE_FWD_EN to hold output until a whole packet (or a full FIFO) is stored.
module bp_axis_pkt_fifo #(
  parameter int N     = 2,
  parameter int D_W   = 32,
  parameter int A_W   = $clog2(N) + 1,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [A_W+D_W-1:0]           s_axis_c_wdata,
  input  logic                         s_axis_c_wvalid,
  output logic                         s_axis_c_wready,
  input  logic                         s_axis_c_wlast,
  output logic [A_W+D_W-1:0]           m_axis_c_wdata,
  output logic                         m_axis_c_wvalid,
  input  logic                         m_axis_c_wready,
  output logic                         m_axis_c_wlast,
  output logic [$clog2(DEPTH):0]       occupancy,
  output logic [$clog2(DEPTH):0]       pkt_cnt
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int FW = A_W + D_W;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [FW:0]   mem_q [DEPTH];
  logic [FW:0]   rd_entry;
  logic          empty, full, wr_en, rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]) &&
                 (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

  assign s_axis_c_wready = !full;

`ifdef PKT_FIFO_STORE_FWD_EN
  // Releasing on full keeps packets longer than DEPTH from deadlocking.
  assign m_axis_c_wvalid = !empty && ((pkt_cnt_q != '0) || full);
`else
  assign m_axis_c_wvalid = !empty;
`endif

  assign wr_en = s_axis_c_wvalid && s_axis_c_wready;
  assign rd_en = m_axis_c_wvalid && m_axis_c_wready;

  assign rd_entry       = mem_q[rd_ptr_q[PW-2:0]];
  assign m_axis_c_wdata = rd_entry[FW-1:0];
  assign m_axis_c_wlast = rd_entry[FW];
  assign occupancy      = wr_ptr_q - rd_ptr_q;
  assign pkt_cnt        = pkt_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_en && s_axis_c_wlast, rd_en && m_axis_c_wlast})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - PW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Storage is intentionally not reset; contents are ignored while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[PW-2:0]] <= {s_axis_c_wlast, s_axis_c_wdata};
  end

endmodule
